// File: rtl/stamp_window.sv
// stamp_window: 8-slot in-order window; slot 7 is oldest, merges unit stamp/take updates, flags RAW hazards, retires from slot 7
// Ports: clk, rst (sync, active-high); in_valid/in_instr/in_ready enqueue; reg_out_flat/reg_start_flat per-slot entry and run code;
//        unit_stamp_flat/unit_stamp_in, unit_take_flat/unit_take_in per-unit updates; count occupancy; retire_valid/retire_instr
module stamp_window #(
  parameter int UNITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [87:0]           in_instr,
  output logic                  in_ready,
  output logic [703:0]          reg_out_flat,
  output logic [23:0]           reg_start_flat,
  input  logic [24*UNITS-1:0]   unit_stamp_flat,
  input  logic [8*UNITS-1:0]    unit_stamp_in,
  input  logic [40*UNITS-1:0]   unit_take_flat,
  input  logic [8*UNITS-1:0]    unit_take_in,
  output logic [3:0]            count,
  output logic                  retire_valid,
  output logic [87:0]           retire_instr
);
  localparam logic [5:0] LUI = 6'b001001;
  localparam logic [87:0] KEEP = ~(88'h7C000_0000 | 88'h7);
  logic [7:0]  vld_q, vld_d;
  logic [87:0] ent_q [8];
  logic [87:0] ent_d [8];
  logic [87:0] mrg [8];
  logic [3:0]  cnt_q, cnt_d;
  logic        rv_q;
  logic [87:0] ri_q;
  logic        ret, enq;
  logic [2:0]  tgt;
  logic [7:0]  haz, owb;
  assign in_ready     = cnt_q != 4'd8;
  assign count        = cnt_q;
  assign retire_valid = rv_q;
  assign retire_instr = ri_q;
  always_comb begin
    ret = vld_q[7] & ent_q[7][2] & ent_q[7][0];
    enq = in_valid & in_ready;
    for (int i = 0; i < 8; i++) begin
      mrg[i] = ent_q[i];
      // descending scan so the lowest-numbered unit's take wins
      for (int u = UNITS - 1; u >= 0; u--) begin
        if (vld_q[i] && unit_stamp_in[8*u+i]) mrg[i][2:0] = mrg[i][2:0] | unit_stamp_flat[24*u+3*i +: 3];
        if (vld_q[i] && unit_take_in[8*u+i]) mrg[i][34:30] = unit_take_flat[40*u+5*i +: 5];
      end
    end
    ent_d[0] = ret ? '0 : mrg[0];
    for (int i = 1; i < 8; i++) ent_d[i] = ret ? mrg[i-1] : mrg[i];
    vld_d = ret ? {vld_q[6:0], 1'b0} : vld_q;
    // free slot after the optional shift
    tgt = ret ? 3'(4'd8 - cnt_q) : 3'(4'd7 - cnt_q);
    if (enq) begin
      vld_d[tgt] = 1'b1;
      ent_d[tgt] = in_instr & KEEP;
    end
    cnt_d = cnt_q + 4'(enq) - 4'(ret);
  end
  always_comb begin
    haz = '0;
    owb = '1;
    reg_out_flat = '0;
    reg_start_flat = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (vld_q[j] && !ent_q[j][0]) begin
          owb[i] = 1'b0;
          if (ent_q[i][87:82] != LUI && ent_q[j][71:67] != 5'd0 &&
              (ent_q[j][71:67] == ent_q[i][81:77] || ent_q[j][71:67] == ent_q[i][76:72])) haz[i] = 1'b1;
        end
      end
      reg_out_flat[88*i +: 88] = vld_q[i] ? ent_q[i] : '0;
      reg_start_flat[3*i +: 3] = !vld_q[i] ? 3'b000 :
                                 (!ent_q[i][2] && !haz[i]) ? 3'b100 :
                                 (ent_q[i][2] && !ent_q[i][0] && owb[i]) ? 3'b001 : 3'b000;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < 8; i++) ent_q[i] <= '0;
      cnt_q <= '0;
      rv_q  <= 1'b0;
      ri_q  <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 8; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
      rv_q  <= ret;
      if (ret) ri_q <= ent_q[7];
    end
  end
endmodule
